// File: rtl/id_ex_if.sv
// ID/EX boundary bundle: decoded ID fields in, registered EX fields and
// the load-use stall enables out.
interface id_ex_if #(
    parameter int DATA_W  = 32,
    parameter int REG_W   = 5,
    parameter int ALUOP_W = 4
);
    logic               id_valid;
    logic [REG_W-1:0]   id_rs;
    logic [REG_W-1:0]   id_rt;
    logic [REG_W-1:0]   id_rd;
    logic               id_uses_rt;
    logic [DATA_W-1:0]  id_rs_data;
    logic [DATA_W-1:0]  id_rt_data;
    logic [DATA_W-1:0]  id_imm;
    logic               id_reg_write;
    logic               id_mem_read;
    logic               id_mem_write;
    logic               id_mem_to_reg;
    logic               id_alu_src;
    logic               id_reg_dst;
    logic [ALUOP_W-1:0] id_alu_op;
    logic               flush;

    logic               ex_valid;
    logic [REG_W-1:0]   ex_rs;
    logic [REG_W-1:0]   ex_rt;
    logic [REG_W-1:0]   ex_rd;
    logic [REG_W-1:0]   ex_dest;
    logic [DATA_W-1:0]  ex_rs_data;
    logic [DATA_W-1:0]  ex_rt_data;
    logic [DATA_W-1:0]  ex_imm;
    logic               ex_reg_write;
    logic               ex_mem_read;
    logic               ex_mem_write;
    logic               ex_mem_to_reg;
    logic               ex_alu_src;
    logic [ALUOP_W-1:0] ex_alu_op;
    logic               pc_write;
    logic               if_id_write;

    modport master (
        output id_valid, id_rs, id_rt, id_rd, id_uses_rt,
        output id_rs_data, id_rt_data, id_imm,
        output id_reg_write, id_mem_read, id_mem_write,
        output id_mem_to_reg, id_alu_src, id_reg_dst, id_alu_op,
        output flush,
        input  ex_valid, ex_rs, ex_rt, ex_rd, ex_dest,
        input  ex_rs_data, ex_rt_data, ex_imm,
        input  ex_reg_write, ex_mem_read, ex_mem_write,
        input  ex_mem_to_reg, ex_alu_src, ex_alu_op,
        input  pc_write, if_id_write
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_rd, id_uses_rt,
        input  id_rs_data, id_rt_data, id_imm,
        input  id_reg_write, id_mem_read, id_mem_write,
        input  id_mem_to_reg, id_alu_src, id_reg_dst, id_alu_op,
        input  flush,
        output ex_valid, ex_rs, ex_rt, ex_rd, ex_dest,
        output ex_rs_data, ex_rt_data, ex_imm,
        output ex_reg_write, ex_mem_read, ex_mem_write,
        output ex_mem_to_reg, ex_alu_src, ex_alu_op,
        output pc_write, if_id_write
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and bubble insert.
// Optional ID_EX_STALL_CNT_EN adds bubble_cnt/flush_cnt counters.
module id_ex_stage #(
    parameter int DATA_W  = 32,
    parameter int REG_W   = 5,
    parameter int ALUOP_W = 4
) (
    input  logic         clk,
    input  logic         rst,
    id_ex_if.slave       bus
`ifdef ID_EX_STALL_CNT_EN
    ,
    output logic [31:0]  bubble_cnt,
    output logic [31:0]  flush_cnt
`endif
);

    typedef struct packed {
        logic               valid;
        logic [REG_W-1:0]   rs;
        logic [REG_W-1:0]   rt;
        logic [REG_W-1:0]   rd;
        logic [REG_W-1:0]   dest;
        logic [DATA_W-1:0]  rs_data;
        logic [DATA_W-1:0]  rt_data;
        logic [DATA_W-1:0]  imm;
        logic               reg_write;
        logic               mem_read;
        logic               mem_write;
        logic               mem_to_reg;
        logic               alu_src;
        logic [ALUOP_W-1:0] alu_op;
    } ex_t;

    ex_t  ex_q, ex_d;
    logic rs_hit, rt_hit, hazard, stall, load;

    always_comb begin
        rs_hit = (ex_q.rt == bus.id_rs);
        rt_hit = bus.id_uses_rt && (ex_q.rt == bus.id_rt);
        hazard = !rst && bus.id_valid && ex_q.valid && ex_q.mem_read
                 && (ex_q.rt != '0) && (rs_hit || rt_hit);
        stall  = hazard && !bus.flush;
        load   = !rst && !bus.flush && !hazard;

        // A bubble is the all-zero record; zero specifiers never forward.
        ex_d = '0;
        if (load) begin
            ex_d.valid      = bus.id_valid;
            ex_d.rs         = bus.id_rs;
            ex_d.rt         = bus.id_rt;
            ex_d.rd         = bus.id_rd;
            ex_d.dest       = bus.id_reg_dst ? bus.id_rd : bus.id_rt;
            ex_d.rs_data    = bus.id_rs_data;
            ex_d.rt_data    = bus.id_rt_data;
            ex_d.imm        = bus.id_imm;
            ex_d.reg_write  = bus.id_valid && bus.id_reg_write;
            ex_d.mem_read   = bus.id_valid && bus.id_mem_read;
            ex_d.mem_write  = bus.id_valid && bus.id_mem_write;
            ex_d.mem_to_reg = bus.id_valid && bus.id_mem_to_reg;
            ex_d.alu_src    = bus.id_valid && bus.id_alu_src;
            ex_d.alu_op     = bus.id_valid ? bus.id_alu_op : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) ex_q <= '0;
        else     ex_q <= ex_d;
    end

    assign bus.ex_valid      = ex_q.valid;
    assign bus.ex_rs         = ex_q.rs;
    assign bus.ex_rt         = ex_q.rt;
    assign bus.ex_rd         = ex_q.rd;
    assign bus.ex_dest       = ex_q.dest;
    assign bus.ex_rs_data    = ex_q.rs_data;
    assign bus.ex_rt_data    = ex_q.rt_data;
    assign bus.ex_imm        = ex_q.imm;
    assign bus.ex_reg_write  = ex_q.reg_write;
    assign bus.ex_mem_read   = ex_q.mem_read;
    assign bus.ex_mem_write  = ex_q.mem_write;
    assign bus.ex_mem_to_reg = ex_q.mem_to_reg;
    assign bus.ex_alu_src    = ex_q.alu_src;
    assign bus.ex_alu_op     = ex_q.alu_op;
    assign bus.pc_write      = !stall;
    assign bus.if_id_write   = !stall;

`ifdef ID_EX_STALL_CNT_EN
    logic [31:0] bubble_cnt_q, bubble_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        bubble_cnt_d = bubble_cnt_q + {31'd0, stall};
        flush_cnt_d  = flush_cnt_q + {31'd0, bus.flush};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign bubble_cnt = bubble_cnt_q;
    assign flush_cnt  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage.
module tb_id_ex_stage;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    id_ex_if #(.DATA_W(32), .REG_W(5), .ALUOP_W(4)) b ();

`ifdef ID_EX_STALL_CNT_EN
    logic [31:0] bcnt, fcnt;
`endif

    id_ex_stage #(.DATA_W(32), .REG_W(5), .ALUOP_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (b)
`ifdef ID_EX_STALL_CNT_EN
        ,
        .bubble_cnt (bcnt),
        .flush_cnt  (fcnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        b.id_valid = 0; b.id_rs = 0; b.id_rt = 0; b.id_rd = 0;
        b.id_uses_rt = 0; b.id_rs_data = 0; b.id_rt_data = 0;
        b.id_imm = 0; b.id_reg_write = 0; b.id_mem_read = 0;
        b.id_mem_write = 0; b.id_mem_to_reg = 0; b.id_alu_src = 0;
        b.id_reg_dst = 0; b.id_alu_op = 0; b.flush = 0;
    endtask

    task automatic lw(input logic [4:0] rs, input logic [4:0] rt);
        nop();
        b.id_valid = 1; b.id_rs = rs; b.id_rt = rt;
        b.id_reg_write = 1; b.id_mem_read = 1; b.id_mem_to_reg = 1;
        b.id_alu_src = 1; b.id_imm = 32'h10;
    endtask

    task automatic rop(input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic ut);
        nop();
        b.id_valid = 1; b.id_rs = rs; b.id_rt = rt; b.id_rd = rd;
        b.id_uses_rt = ut; b.id_reg_dst = 1; b.id_reg_write = 1;
        b.id_alu_op = 4'd2; b.id_rs_data = 32'hA5A5_0001;
        b.id_rt_data = 32'h5A5A_0002;
    endtask

    initial begin
        // reset with random ID inputs
        nop();
        rst = 1;
        b.id_valid = 1'($urandom); b.id_rs = 5'($urandom);
        b.id_rt = 5'($urandom); b.id_rd = 5'($urandom);
        b.id_rs_data = $urandom; b.id_imm = $urandom;
        b.id_mem_read = 1'($urandom); b.id_alu_op = 4'($urandom);
        #1;
        chk("rst_pcw", b.pc_write, 1);
        step(); step();
        chk("rst_valid", b.ex_valid, 0);
        chk("rst_spec", {b.ex_rs, b.ex_rt, b.ex_rd, b.ex_dest}, 0);
        chk("rst_data", {b.ex_rs_data, b.ex_rt_data}, 0);
        chk("rst_ctl", {b.ex_reg_write, b.ex_mem_read, b.ex_mem_write,
                        b.ex_mem_to_reg, b.ex_alu_src, b.ex_alu_op}, 0);
        chk("rst_ifid", b.if_id_write, 1);
`ifdef ID_EX_STALL_CNT_EN
        chk("rst_cnt", {bcnt, fcnt}, 0);
`endif

        // pass-through
        rst = 0;
        rop(5'd3, 5'd4, 5'd5, 1);
        #1;
        chk("pt_pcw", b.pc_write, 1);
        step();
        chk("pt_spec", {b.ex_rs, b.ex_rt, b.ex_rd, b.ex_dest},
            {5'd3, 5'd4, 5'd5, 5'd5});
        chk("pt_ctl", {b.ex_valid, b.ex_reg_write, b.ex_alu_op,
                       b.ex_mem_read}, {1'b1, 1'b1, 4'd2, 1'b0});
        chk("pt_data", b.ex_rs_data, 32'hA5A5_0001);

        // load-use on rs
        lw(5'd1, 5'd8);
        step();
        chk("lw_ex", {b.ex_rt, b.ex_dest, b.ex_mem_read, b.ex_imm},
            {5'd8, 5'd8, 1'b1, 32'h10});
        rop(5'd8, 5'd2, 5'd10, 1);
        #1;
        chk("lu_stall", {b.pc_write, b.if_id_write}, 2'b00);
        step();
        chk("lu_bub", {b.ex_valid, b.ex_rs, b.ex_reg_write,
                       b.ex_rs_data}, 0);
        chk("lu_release", {b.pc_write, b.if_id_write}, 2'b11);
        step();
        chk("lu_load", {b.ex_valid, b.ex_rs, b.ex_dest},
            {1'b1, 5'd8, 5'd10});
`ifdef ID_EX_STALL_CNT_EN
        chk("lu_bcnt", bcnt, 1);
`endif

        // rt-only dependency
        lw(5'd1, 5'd9);
        step();
        rop(5'd1, 5'd9, 5'd11, 0);
        #1;
        chk("rt_nouse", b.pc_write, 1);
        b.id_uses_rt = 1;
        #1;
        chk("rt_use", b.pc_write, 0);
        step();
        chk("rt_bub", {b.ex_valid, b.ex_rt}, 0);
        step();
        chk("rt_load", {b.ex_valid, b.ex_rt, b.ex_dest},
            {1'b1, 5'd9, 5'd11});

        // register 0 is never a hazard
        lw(5'd2, 5'd0);
        step();
        chk("r0_ex", {b.ex_mem_read, b.ex_rt}, {1'b1, 5'd0});
        rop(5'd0, 5'd0, 5'd12, 1);
        #1;
        chk("r0_nostall", b.pc_write, 1);

        // invalid ID: no hazard, control bits zero
        lw(5'd1, 5'd7);
        step();
        rop(5'd7, 5'd7, 5'd13, 1);
        b.id_valid = 0; b.id_mem_write = 1;
        #1;
        chk("inv_nostall", b.pc_write, 1);
        step();
        chk("inv_ctl", {b.ex_valid, b.ex_reg_write, b.ex_mem_write,
                        b.ex_alu_op}, 0);
        chk("inv_spec", b.ex_rs, 5'd7);

        // back-to-back dependent loads
        lw(5'd1, 5'd8);
        step();
        lw(5'd8, 5'd9);
        #1;
        chk("ll_stall1", b.pc_write, 0);
        step();
        chk("ll_bub1", b.ex_valid, 0);
        step();
        chk("ll_ld2", {b.ex_rt, b.ex_mem_read}, {5'd9, 1'b1});
        rop(5'd9, 5'd3, 5'd14, 1);
        #1;
        chk("ll_stall2", b.if_id_write, 0);
        step();
        chk("ll_bub2", {b.ex_valid, b.ex_rd}, 0);
`ifdef ID_EX_STALL_CNT_EN
        chk("ll_bcnt", bcnt, 4);
`endif

        // flush beats hazard
        lw(5'd1, 5'd8);
        step();
        rop(5'd8, 5'd2, 5'd15, 1);
        b.flush = 1;
        #1;
        chk("fl_pcw", {b.pc_write, b.if_id_write}, 2'b11);
        step();
        chk("fl_bub", {b.ex_valid, b.ex_rs, b.ex_dest, b.ex_reg_write}, 0);
`ifdef ID_EX_STALL_CNT_EN
        chk("fl_cnt", {bcnt, fcnt}, {32'd4, 32'd1});
`endif

        // reset mid-stall
        lw(5'd1, 5'd8);
        step();
        rop(5'd8, 5'd2, 5'd16, 1);
        #1;
        chk("rs_stall", b.pc_write, 0);
        rst = 1;
        #1;
        chk("rs_release", {b.pc_write, b.if_id_write}, 2'b11);
        step();
        chk("rs_clear", {b.ex_valid, b.ex_rs, b.ex_rt, b.ex_mem_read}, 0);
`ifdef ID_EX_STALL_CNT_EN
        chk("rs_cnt", {bcnt, fcnt}, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
